id_exe: RTL and testbench

- Pipeline register between the ID and EXE stages of the 5-stage RV32I core. It captures the decoded instruction, operands and write-back control from ID.
- It inserts bubbles for load-use hazards, flushes and interrupts, and holds its contents under downstream stalls.
- It drives the load-hazard feedback (pre_inst_is_load_o, exe_rd_o) back into ID.

---
 rtl/id_exe.sv | 108 ++++++++++
 tb/tb_id_exe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/id_exe.sv
// ID/EXE pipeline register: bubbles on stall/flush, holds on downstream wait.
// Optional ID_EXE_BUBBLE_CNT_EN adds a load-use bubble counter output.
module id_exe #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DATA_W-1:0]  inst_i,
    input  logic [ADDR_W-1:0]  inst_addr_i,
    input  logic [DATA_W-1:0]  op1_i,
    input  logic [DATA_W-1:0]  op2_i,
    input  logic               reg_we_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               stallreq_i,
    input  logic               hold_i,
    input  logic               flush_i,
    output logic [DATA_W-1:0]  inst_o,
    output logic [ADDR_W-1:0]  inst_addr_o,
    output logic [DATA_W-1:0]  op1_o,
    output logic [DATA_W-1:0]  op2_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               valid_o,
    output logic               pre_inst_is_load_o,
    output logic [RADDR_W-1:0] exe_rd_o,
`ifdef ID_EXE_BUBBLE_CNT_EN
    output logic [31:0]        bubble_cnt_o,
`endif
    output logic [1:0]         state_o
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);
    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        LUBUB = 2'd2,
        ILL   = 2'd3
    } state_t;

    state_t state;

    // Flush and the unreachable encoding both collapse the slot to a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= EMPTY;
            inst_o      <= NOP;
            inst_addr_o <= '0;
            op1_o       <= '0;
            op2_o       <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            valid_o     <= 1'b0;
        end else if (flush_i || state == ILL) begin
            state       <= EMPTY;
            inst_o      <= NOP;
            inst_addr_o <= '0;
            op1_o       <= '0;
            op2_o       <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            valid_o     <= 1'b0;
        end else if (!hold_i) begin
            if (stallreq_i) begin
                state       <= LUBUB;
                inst_o      <= NOP;
                inst_addr_o <= '0;
                op1_o       <= '0;
                op2_o       <= '0;
                reg_we_o    <= 1'b0;
                reg_waddr_o <= '0;
                valid_o     <= 1'b0;
            end else begin
                state       <= FULL;
                inst_o      <= inst_i;
                inst_addr_o <= inst_addr_i;
                op1_o       <= op1_i;
                op2_o       <= op2_i;
                reg_we_o    <= reg_we_i;
                reg_waddr_o <= reg_waddr_i;
                valid_o     <= 1'b1;
            end
        end
    end

`ifdef ID_EXE_BUBBLE_CNT_EN
    // Only load-use bubbles are counted; flush bubbles are not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_o <= '0;
        end else if (!flush_i && state != ILL && !hold_i && stallreq_i) begin
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif

    assign state_o = state;

    assign pre_inst_is_load_o = valid_o
                             && (inst_o[6:0] == OPC_LOAD)
                             && (reg_waddr_o != '0);

    assign exe_rd_o = valid_o ? reg_waddr_o : '0;

endmodule

// File: tb/tb_id_exe.sv
// Directed scoreboard bench for the ID/EXE pipeline register.
module tb_id_exe;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        we;
        logic [4:0]  wa;
        logic        valid;
        logic        load;
        logic [4:0]  rd;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, addr_i, op1_i, op2_i;
    logic        we_i;
    logic [4:0]  wa_i;
    logic        stall, hold, flush;
    logic [31:0] inst_o, addr_o, op1_o, op2_o;
    logic        we_o, valid_o, load_o;
    logic [4:0]  wa_o, rd_o;
    logic [1:0]  st_o;
    logic [31:0] cnt_o;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [31:0] ecnt = 0;

    id_exe dut (
        .clk_i(clk), .rst_i(rst),
        .inst_i(inst_i), .inst_addr_i(addr_i),
        .op1_i(op1_i), .op2_i(op2_i),
        .reg_we_i(we_i), .reg_waddr_i(wa_i),
        .stallreq_i(stall), .hold_i(hold), .flush_i(flush),
        .inst_o(inst_o), .inst_addr_o(addr_o),
        .op1_o(op1_o), .op2_o(op2_o),
        .reg_we_o(we_o), .reg_waddr_o(wa_o),
        .valid_o(valid_o), .pre_inst_is_load_o(load_o),
        .exe_rd_o(rd_o),
`ifdef ID_EXE_BUBBLE_CNT_EN
        .bubble_cnt_o(cnt_o),
`endif
        .state_o(st_o)
    );

`ifndef ID_EXE_BUBBLE_CNT_EN
    assign cnt_o = ecnt;
`endif

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [31:0] i, logic [31:0] a,
                                logic [31:0] o1, logic [31:0] o2,
                                logic w, logic [4:0] r, logic v,
                                logic l, logic [4:0] d, logic [1:0] s,
                                logic [31:0] c);
        mk = '{i, a, o1, o2, w, r, v, l, d, s, c};
    endfunction

    function automatic exp_t bub(logic [1:0] s, logic [31:0] c);
        bub = mk(32'h13, 0, 0, 0, 0, 0, 0, 0, 0, s, c);
    endfunction

    function automatic exp_t obs();
        obs = mk(inst_o, addr_o, op1_o, op2_o, we_o, wa_o,
                 valid_o, load_o, rd_o, st_o, cnt_o);
    endfunction

    task automatic cmp(string tag, exp_t e);
        exp_t o;
        o = obs();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic step(string tag, logic [31:0] i, logic [31:0] a,
                        logic [31:0] o1, logic [31:0] o2, logic w,
                        logic [4:0] r, logic s, logic h, logic f,
                        exp_t e);
        exp_t got;
        @(negedge clk);
        inst_i = i; addr_i = a; op1_i = o1; op2_i = o2;
        we_i = w; wa_i = r; stall = s; hold = h; flush = f;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        cmp(tag, got);
    endtask

    localparam logic [31:0] ADDI = 32'h0030_8093;
    localparam logic [31:0] LW5  = 32'h0001_2283;
    localparam logic [31:0] LW0  = 32'h0001_2003;
    localparam logic [31:0] ADD3 = 32'h0020_81b3;
    localparam logic [31:0] SUB4 = 32'h4020_8233;

    exp_t e_add3, e_lw5;

    initial begin
        rst = 1'b1;
        inst_i = 0; addr_i = 0; op1_i = 0; op2_i = 0;
        we_i = 0; wa_i = 0; stall = 0; hold = 0; flush = 0;
        #3;
        cmp("reset", bub(2'd0, 0));
        @(negedge clk);
        rst = 1'b0;

        step("addi", ADDI, 32'h100, 5, 7, 1, 1, 0, 0, 0,
             mk(ADDI, 32'h100, 5, 7, 1, 1, 1, 0, 1, 2'd1, ecnt));

        e_lw5 = mk(LW5, 32'h104, 32'h2000, 0, 1, 5, 1, 1, 5, 2'd1, ecnt);
        step("lw_x5", LW5, 32'h104, 32'h2000, 0, 1, 5, 0, 0, 0, e_lw5);

        ecnt = ecnt + 1;
        step("lu_bubble", 32'hDEAD_BEEF, 32'h108, 9, 9, 1, 6, 1, 0, 0,
             bub(2'd2, ecnt));

        step("lw_x0", LW0, 32'h10C, 32'h2000, 0, 1, 0, 0, 0, 0,
             mk(LW0, 32'h10C, 32'h2000, 0, 1, 0, 1, 0, 0, 2'd1, ecnt));

        e_add3 = mk(ADD3, 32'h110, 11, 22, 1, 3, 1, 0, 3, 2'd1, ecnt);
        step("add_x3", ADD3, 32'h110, 11, 22, 1, 3, 0, 0, 0, e_add3);
        for (int k = 0; k < 3; k++)
            step("hold", 32'h1111_0000 + k, 32'h200 + k, k, k, 1,
                 5'(k + 8), 0, 1, 0, e_add3);

        step("after_hold", SUB4, 32'h114, 30, 4, 1, 4, 0, 0, 0,
             mk(SUB4, 32'h114, 30, 4, 1, 4, 1, 0, 4, 2'd1, ecnt));

        step("flush_stall", ADDI, 32'h118, 1, 1, 1, 1, 1, 0, 1,
             bub(2'd0, ecnt));

        e_lw5 = mk(LW5, 32'h11C, 32'h40, 0, 1, 5, 1, 1, 5, 2'd1, ecnt);
        step("lw_x5_b", LW5, 32'h11C, 32'h40, 0, 1, 5, 0, 0, 0, e_lw5);
        step("flush_hold", ADDI, 32'h120, 1, 1, 1, 1, 0, 1, 1,
             bub(2'd0, ecnt));

        e_lw5 = mk(LW5, 32'h124, 32'h80, 0, 1, 5, 1, 1, 5, 2'd1, ecnt);
        step("lw_x5_c", LW5, 32'h124, 32'h80, 0, 1, 5, 0, 0, 0, e_lw5);
        step("hold_stall", ADDI, 32'h128, 1, 1, 1, 1, 1, 1, 0, e_lw5);

        ecnt = ecnt + 1;
        step("stall_1", ADDI, 32'h12C, 1, 1, 1, 1, 1, 0, 0,
             bub(2'd2, ecnt));
        ecnt = ecnt + 1;
        step("stall_2", ADDI, 32'h12C, 1, 1, 1, 1, 1, 0, 0,
             bub(2'd2, ecnt));

        step("we0_waddr", ADD3, 32'h130, 3, 4, 0, 7, 0, 0, 0,
             mk(ADD3, 32'h130, 3, 4, 0, 7, 1, 0, 7, 2'd1, ecnt));

        #2;
        rst = 1'b1;
        ecnt = 0;
        #1;
        cmp("async_reset", bub(2'd0, ecnt));
        @(negedge clk);
        cmp("reset_held", bub(2'd0, ecnt));
        rst = 1'b0;

        step("post_reset", ADDI, 32'h140, 5, 0, 1, 1, 0, 0, 0,
             mk(ADDI, 32'h140, 5, 0, 1, 1, 1, 0, 1, 2'd1, ecnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
